// File: rtl/uart_pkg.sv
// Shared constants and state types for the UART echo front end.
//   DEF_*         default clock / baud / oversampling settings
//   DATA_BITS     payload bits per frame
//   TICK_DIV      oversample divider at the default settings
//   rx_state_t / tx_state_t  receiver and transmitter FSM states
package uart_pkg;

    localparam int unsigned DEF_CLOCK_FREQ    = 100_000_000;
    localparam int unsigned DEF_BAUD_RATE     = 9600;
    localparam int unsigned DEF_SAMPLING_RATE = 16;
    localparam int unsigned DATA_BITS         = 8;

    // Clocks per oversample tick (integer division).
    function automatic int unsigned calc_tick_div(input int unsigned clk_hz,
                                                  input int unsigned baud,
                                                  input int unsigned sr);
        return clk_hz / (baud * sr);
    endfunction

    localparam int unsigned TICK_DIV =
        calc_tick_div(DEF_CLOCK_FREQ, DEF_BAUD_RATE, DEF_SAMPLING_RATE);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-clk oversample tick every DIV clocks.
//   clk   system clock
//   rst   synchronous active-high reset
//   tick  one-clk pulse, period DIV clocks
module uart_baud_tick #(
    parameter int unsigned DIV = 651
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    // Wrap at DIV-1 and flag the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_echo.sv
// 8N1 UART receiver and transmitter; every valid received byte is echoed.
//   clk, rst   system clock, synchronous active-high reset
//   RsRx       serial input (idle high, asynchronous)
//   RsTx       serial output (idle high)
//   data_out   last correctly framed byte
//   receiving  RX frame in progress
//   received   one-clk pulse when data_out has been updated
//   sending    TX frame on RsTx
//   sent       one-clk pulse at the end of a TX stop bit
module uart_echo
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ    = DEF_CLOCK_FREQ,
    parameter int unsigned BAUD_RATE     = DEF_BAUD_RATE,
    parameter int unsigned SAMPLING_RATE = DEF_SAMPLING_RATE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RsRx,
    output logic                 RsTx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 receiving,
    output logic                 received,
    output logic                 sending,
    output logic                 sent
);

    localparam int unsigned DIV = calc_tick_div(CLOCK_FREQ, BAUD_RATE, SAMPLING_RATE);
    localparam int unsigned TW  = $clog2(SAMPLING_RATE);
    localparam int unsigned BW  = $clog2(DATA_BITS);
    localparam logic [TW-1:0] HALF_LAST = TW'(SAMPLING_RATE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(SAMPLING_RATE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic tick;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // ---------------- receiver ----------------
    logic                 rx_meta, rx_sync;
    rx_state_t            rx_state, rx_state_nx;
    logic [TW-1:0]        rx_tcnt, rx_tcnt_nx;
    logic [BW-1:0]        rx_bcnt, rx_bcnt_nx;
    logic [DATA_BITS-1:0] rx_sh, rx_sh_nx, data_out_nx;
    logic                 rx_ferr, rx_ferr_nx;
    logic                 rx_done, rx_done_nx;

    // rx_done delays the received pulse one clk behind the data_out load.
    always_comb begin
        rx_state_nx = rx_state;
        rx_tcnt_nx  = rx_tcnt;
        rx_bcnt_nx  = rx_bcnt;
        rx_sh_nx    = rx_sh;
        rx_ferr_nx  = rx_ferr;
        rx_done_nx  = 1'b0;
        data_out_nx = data_out;
        case (rx_state)
            RX_IDLE: begin
                if (!rx_sync) begin
                    rx_state_nx = RX_START;
                    rx_tcnt_nx  = '0;
                    rx_bcnt_nx  = '0;
                    rx_ferr_nx  = 1'b0;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (rx_tcnt == HALF_LAST) begin
                        rx_tcnt_nx  = '0;
                        rx_state_nx = rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_tcnt_nx = rx_tcnt + TW'(1);
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (rx_tcnt == FULL_LAST) begin
                        rx_tcnt_nx = '0;
                        rx_sh_nx   = {rx_sync, rx_sh[DATA_BITS-1:1]};
                        if (rx_bcnt == BIT_LAST) rx_state_nx = RX_STOP;
                        else                     rx_bcnt_nx  = rx_bcnt + BW'(1);
                    end else begin
                        rx_tcnt_nx = rx_tcnt + TW'(1);
                    end
                end
            end
            RX_STOP: begin
                if (rx_ferr) begin
                    // Framing error: wait for the line to recover before rearming.
                    if (rx_sync) rx_state_nx = RX_IDLE;
                end else if (tick) begin
                    if (rx_tcnt == FULL_LAST) begin
                        rx_tcnt_nx = '0;
                        if (rx_sync) begin
                            data_out_nx = rx_sh;
                            rx_done_nx  = 1'b1;
                            rx_state_nx = RX_IDLE;
                        end else begin
                            rx_ferr_nx = 1'b1;
                        end
                    end else begin
                        rx_tcnt_nx = rx_tcnt + TW'(1);
                    end
                end
            end
            default: rx_state_nx = RX_IDLE;
        endcase
    end

    // ---------------- transmitter ----------------
    tx_state_t            tx_state, tx_state_nx;
    logic [TW-1:0]        tx_tcnt, tx_tcnt_nx;
    logic [BW-1:0]        tx_bcnt, tx_bcnt_nx;
    logic [DATA_BITS-1:0] tx_sh, tx_sh_nx;
    logic                 tx_line_nx, sending_nx, sent_nx;

    // A received pulse while busy is ignored, so the active frame is untouched.
    always_comb begin
        tx_state_nx = tx_state;
        tx_tcnt_nx  = tx_tcnt;
        tx_bcnt_nx  = tx_bcnt;
        tx_sh_nx    = tx_sh;
        tx_line_nx  = RsTx;
        sending_nx  = sending;
        sent_nx     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_line_nx = 1'b1;
                if (received) begin
                    tx_state_nx = TX_START;
                    tx_sh_nx    = data_out;
                    tx_tcnt_nx  = '0;
                    tx_bcnt_nx  = '0;
                    tx_line_nx  = 1'b0;
                    sending_nx  = 1'b1;
                end
            end
            TX_START: begin
                if (tick) begin
                    if (tx_tcnt == FULL_LAST) begin
                        tx_tcnt_nx  = '0;
                        tx_line_nx  = tx_sh[0];
                        tx_state_nx = TX_DATA;
                    end else begin
                        tx_tcnt_nx = tx_tcnt + TW'(1);
                    end
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (tx_tcnt == FULL_LAST) begin
                        tx_tcnt_nx = '0;
                        if (tx_bcnt == BIT_LAST) begin
                            tx_state_nx = TX_STOP;
                            tx_line_nx  = 1'b1;
                        end else begin
                            tx_bcnt_nx = tx_bcnt + BW'(1);
                            tx_sh_nx   = tx_sh >> 1;
                            tx_line_nx = tx_sh[1];
                        end
                    end else begin
                        tx_tcnt_nx = tx_tcnt + TW'(1);
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    if (tx_tcnt == FULL_LAST) begin
                        tx_tcnt_nx  = '0;
                        tx_state_nx = TX_IDLE;
                        tx_line_nx  = 1'b1;
                        sending_nx  = 1'b0;
                        sent_nx     = 1'b1;
                    end else begin
                        tx_tcnt_nx = tx_tcnt + TW'(1);
                    end
                end
            end
            default: tx_state_nx = TX_IDLE;
        endcase
    end

    // State and output registers; receiving stays up through the pending-pulse clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_state  <= RX_IDLE;
            rx_tcnt   <= '0;
            rx_bcnt   <= '0;
            rx_sh     <= '0;
            rx_ferr   <= 1'b0;
            rx_done   <= 1'b0;
            data_out  <= '0;
            receiving <= 1'b0;
            received  <= 1'b0;
            tx_state  <= TX_IDLE;
            tx_tcnt   <= '0;
            tx_bcnt   <= '0;
            tx_sh     <= '0;
            RsTx      <= 1'b1;
            sending   <= 1'b0;
            sent      <= 1'b0;
        end else begin
            rx_meta   <= RsRx;
            rx_sync   <= rx_meta;
            rx_state  <= rx_state_nx;
            rx_tcnt   <= rx_tcnt_nx;
            rx_bcnt   <= rx_bcnt_nx;
            rx_sh     <= rx_sh_nx;
            rx_ferr   <= rx_ferr_nx;
            rx_done   <= rx_done_nx;
            data_out  <= data_out_nx;
            receiving <= (rx_state_nx != RX_IDLE) || rx_done_nx;
            received  <= rx_done;
            tx_state  <= tx_state_nx;
            tx_tcnt   <= tx_tcnt_nx;
            tx_bcnt   <= tx_bcnt_nx;
            tx_sh     <= tx_sh_nx;
            RsTx      <= tx_line_nx;
            sending   <= sending_nx;
            sent      <= sent_nx;
        end
    end

endmodule

// File: tb/tb_uart_echo.sv
// Directed bench for uart_echo, run with a scaled clock so one bit is 64 clk.
module tb_uart_echo;

    localparam int unsigned CLK_HZ  = 614_400;   // 9600 * 16 * 4 -> 4 clk per tick
    localparam int unsigned BAUD    = 9600;
    localparam int unsigned SR      = 16;
    localparam int unsigned BIT_CLK = 64;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       RsRx = 1'b1;
    logic       RsTx;
    logic [7:0] data_out;
    logic       receiving, received, sending, sent;

    uart_echo #(
        .CLOCK_FREQ    (CLK_HZ),
        .BAUD_RATE     (BAUD),
        .SAMPLING_RATE (SR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .RsRx      (RsRx),
        .RsTx      (RsTx),
        .data_out  (data_out),
        .receiving (receiving),
        .received  (received),
        .sending   (sending),
        .sent      (sent)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output event monitor.
    int unsigned n_recv = 0, n_sent = 0, n_send_rise = 0;
    logic [7:0]  rx_q[$];
    logic [7:0]  pre_q[$];
    logic [9:0]  tx_q[$];
    logic [7:0]  dout_prev = 8'h00;
    logic        sending_prev = 1'b0;
    logic        rcv_mid = 1'b0;

    always @(negedge clk) begin
        if (received === 1'b1) begin
            n_recv++;
            rx_q.push_back(data_out);
            pre_q.push_back(dout_prev);
        end
        if (sent === 1'b1) n_sent++;
        if (sending === 1'b1 && sending_prev !== 1'b1) n_send_rise++;
        dout_prev    = data_out;
        sending_prev = sending;
    end

    // RsTx frame decoder sampling at bit centres: {stop, data[7:0], start}.
    initial begin
        logic [9:0] fr;
        forever begin
            @(negedge clk);
            if (!rst && RsTx === 1'b0) begin
                repeat (BIT_CLK / 2) @(negedge clk);
                fr[0] = RsTx;
                for (int i = 1; i < 10; i++) begin
                    repeat (BIT_CLK) @(negedge clk);
                    fr[i] = RsTx;
                end
                tx_q.push_back(fr);
            end
        end
    end

    function automatic logic [7:0] rx_at(input int i);
        return (i < rx_q.size()) ? rx_q[i] : 8'hxx;
    endfunction
    function automatic logic [7:0] pre_at(input int i);
        return (i < pre_q.size()) ? pre_q[i] : 8'hxx;
    endfunction
    function automatic logic [9:0] tx_at(input int i);
        return (i < tx_q.size()) ? tx_q[i] : 10'hxxx;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int gap_clk);
        RsRx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RsRx = b[i];
            repeat (BIT_CLK) @(negedge clk);
            if (i == 3) rcv_mid = receiving;
        end
        RsRx = stop_bit;
        repeat (BIT_CLK) @(negedge clk);
        RsRx = 1'b1;
        repeat (gap_clk) @(negedge clk);
    endtask

    task automatic wait_sent(input int unsigned target, input string tag);
        for (int i = 0; i < 3000 && n_sent < target; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk(tag, n_sent, target);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        RsRx = 1'b1;
        rst  = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_RsTx",      RsTx,      1);
        chk("rst_data_out",  data_out,  0);
        chk("rst_receiving", receiving, 0);
        chk("rst_received",  received,  0);
        chk("rst_sending",   sending,   0);
        chk("rst_sent",      sent,      0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_recv_cnt", n_recv, 0);
        chk("idle_send_cnt", n_send_rise, 0);
        chk("idle_RsTx",     RsTx, 1);
        chk("idle_receiving", receiving, 0);

        // Single byte 0xA5 and its echo
        send_byte(8'hA5, 1'b1, 0);
        chk("a5_receiving_mid", rcv_mid, 1);
        chk("a5_recv_cnt",      n_recv, 1);
        chk("a5_data",          rx_at(0), 8'hA5);
        chk("a5_data_pre",      pre_at(0), 8'hA5);
        wait_sent(1, "a5_sent_cnt");
        chk("a5_tx_frame",      tx_at(0), {1'b1, 8'hA5, 1'b0});
        chk("a5_sending_low",   sending, 0);

        // Back-to-back 0x55, 0xAA with half-bit gap
        send_byte(8'h55, 1'b1, BIT_CLK / 2);
        send_byte(8'hAA, 1'b1, 0);
        wait_sent(3, "b2b_sent_cnt");
        chk("b2b_recv_cnt",  n_recv, 3);
        chk("b2b_data0",     rx_at(1), 8'h55);
        chk("b2b_data1",     rx_at(2), 8'hAA);
        chk("b2b_tx0",       tx_at(1), {1'b1, 8'h55, 1'b0});
        chk("b2b_tx1",       tx_at(2), {1'b1, 8'hAA, 1'b0});

        // Loopback 0x33
        send_byte(8'h33, 1'b1, 0);
        wait_sent(4, "lb_sent_cnt");
        chk("lb_send_rise",  n_send_rise, 4);
        chk("lb_data",       rx_at(3), 8'h33);
        chk("lb_tx_frame",   tx_at(3), {1'b1, 8'h33, 1'b0});
        chk("lb_sending_low", sending, 0);

        // Framing error 0x5A, then valid 0x12
        send_byte(8'h5A, 1'b0, BIT_CLK);
        repeat (200) @(negedge clk);
        chk("fe_recv_cnt",   n_recv, 4);
        chk("fe_data_kept",  data_out, 8'h33);
        chk("fe_no_tx",      n_send_rise, 4);
        chk("fe_receiving",  receiving, 0);
        send_byte(8'h12, 1'b1, 0);
        wait_sent(5, "fe_next_sent_cnt");
        chk("fe_next_data",  rx_at(4), 8'h12);
        chk("fe_next_tx",    tx_at(4), {1'b1, 8'h12, 1'b0});

        // Glitch: 2-tick low pulse
        RsRx = 1'b0;
        repeat (8) @(negedge clk);
        RsRx = 1'b1;
        repeat (4) @(negedge clk);
        chk("gl_receiving_hi", receiving, 1);
        repeat (100) @(negedge clk);
        chk("gl_receiving_lo", receiving, 0);
        chk("gl_recv_cnt",     n_recv, 5);

        // Reset in the middle of a TX frame
        send_byte(8'h77, 1'b1, 0);
        for (int i = 0; i < 200 && sending !== 1'b1; i++) @(negedge clk);
        chk("mr_sending_hi", sending, 1);
        repeat (200) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_RsTx",      RsTx, 1);
        chk("mr_sending",   sending, 0);
        chk("mr_data_out",  data_out, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (1000) @(negedge clk);
        chk("mr_no_sent",   n_sent, 5);
        chk("mr_recv_cnt",  n_recv, 6);
        chk("mr_RsTx_idle", RsTx, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
